// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a one-entry holding register in front of the shifter.
// Configurable data width, parity mode and stop-bit count; back-to-back frames run with no idle gap.
module uart_tx_param #(
   parameter int CLKS_PER_BIT = 104,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic                 i_Tx_DV,
   input  logic [DATA_BITS-1:0] i_Tx_Byte,
   output logic                 o_Tx_Ready,
   output logic                 o_Tx_Active,
   output logic                 o_Tx_Serial,
   output logic                 o_Tx_Done
);

   localparam int              CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic            ODD       = (PARITY == 2);

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

   state_t               state, state_n;
   logic [CW-1:0]        cnt, cnt_n;
   logic [3:0]           bit_idx, bit_n;
   logic [DATA_BITS-1:0] shift, shift_n;
   logic [DATA_BITS-1:0] hold, hold_n;
   logic                 full, full_n;
   logic                 par, par_n;
   logic                 serial, serial_n;
   logic                 done, done_n;
   logic                 load;
   logic                 cnt_last;

   assign cnt_last = (cnt == CNT_LAST);

   always_comb begin
      state_n  = state;
      bit_n    = bit_idx;
      shift_n  = shift;
      hold_n   = hold;
      full_n   = full;
      par_n    = par;
      serial_n = serial;
      done_n   = 1'b0;
      load     = 1'b0;
      cnt_n    = (state == ST_IDLE || cnt_last) ? '0 : cnt + 1'b1;

      case (state)
         ST_IDLE: begin
            serial_n = 1'b1;
            load     = full;
         end
         ST_START: begin
            if (cnt_last) begin
               state_n  = ST_DATA;
               serial_n = shift[0];
               bit_n    = '0;
            end
         end
         ST_DATA: begin
            if (cnt_last) begin
               if (bit_idx == DATA_LAST) begin
                  bit_n = '0;
                  if (PARITY != 0) begin
                     state_n  = ST_PARITY;
                     serial_n = par;
                  end else begin
                     state_n  = ST_STOP;
                     serial_n = 1'b1;
                  end
               end else begin
                  // shift[1] is the next data bit once this shift lands
                  bit_n    = bit_idx + 1'b1;
                  shift_n  = shift >> 1;
                  serial_n = shift[1];
               end
            end
         end
         ST_PARITY: begin
            if (cnt_last) begin
               state_n  = ST_STOP;
               serial_n = 1'b1;
               bit_n    = '0;
            end
         end
         ST_STOP: begin
            if (cnt_last) begin
               if (bit_idx == STOP_LAST) begin
                  done_n = 1'b1;
                  if (full) begin
                     load = 1'b1;
                  end else begin
                     state_n  = ST_IDLE;
                     serial_n = 1'b1;
                  end
               end else begin
                  bit_n = bit_idx + 1'b1;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase

      // Load and accept are exclusive: load needs a full register, accept an empty one.
      if (load) begin
         state_n  = ST_START;
         serial_n = 1'b0;
         shift_n  = hold;
         par_n    = (^hold) ^ ODD;
         full_n   = 1'b0;
         cnt_n    = '0;
         bit_n    = '0;
      end else if (i_Tx_DV && !full) begin
         full_n = 1'b1;
         hold_n = i_Tx_Byte;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         hold    <= '0;
         full    <= 1'b0;
         par     <= 1'b0;
         serial  <= 1'b1;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_n;
         shift   <= shift_n;
         hold    <= hold_n;
         full    <= full_n;
         par     <= par_n;
         serial  <= serial_n;
         done    <= done_n;
      end
   end

   assign o_Tx_Ready  = ~full;
   assign o_Tx_Active = (state != ST_IDLE);
   assign o_Tx_Serial = serial;
   assign o_Tx_Done   = done;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: five configurations share one stimulus stream, each checked every
// cycle against a frame-level reference model, plus directed checks of the key scenarios.
module tb_uart_tx_param;

   localparam int N = 5;
   localparam int CPB [N] = '{4, 4, 4, 2, 4};
   localparam int DB  [N] = '{8, 7, 7, 9, 8};
   localparam int PAR [N] = '{0, 1, 2, 2, 0};
   localparam int STB [N] = '{1, 1, 1, 2, 2};

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         dv  = 1'b0;
   logic [8:0]   tx_byte = '0;
   logic [N-1:0] ready, active, serial, done;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      uart_tx_param #(
         .CLKS_PER_BIT(CPB[g]),
         .DATA_BITS   (DB[g]),
         .PARITY      (PAR[g]),
         .STOP_BITS   (STB[g])
      ) u_dut (
         .i_Clock    (clk),
         .i_Reset    (rst),
         .i_Tx_DV    (dv),
         .i_Tx_Byte  (tx_byte[DB[g]-1:0]),
         .o_Tx_Ready (ready[g]),
         .o_Tx_Active(active[g]),
         .o_Tx_Serial(serial[g]),
         .o_Tx_Done  (done[g])
      );
   end

   // Reference model: a frame is a bit vector; line level = frame[t / CLKS_PER_BIT].
   bit          m_busy [N];
   bit          m_full [N];
   bit          m_done [N];
   int          m_t    [N];
   logic [12:0] m_frame[N];
   logic [8:0]  m_hold [N];

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   function automatic int frame_len(int d);
      return (1 + DB[d] + ((PAR[d] != 0) ? 1 : 0) + STB[d]) * CPB[d];
   endfunction

   function automatic logic [12:0] build(int d, logic [8:0] data);
      logic [12:0] f;
      logic        p;
      f    = '1;
      f[0] = 1'b0;
      p    = 1'b0;
      for (int i = 0; i < DB[d]; i++) begin
         f[1+i] = data[i];
         p      = p ^ data[i];
      end
      if (PAR[d] != 0) f[1+DB[d]] = p ^ (PAR[d] == 2);
      return f;
   endfunction

   task automatic model_step();
      bit acc;
      for (int d = 0; d < N; d++) begin
         if (rst) begin
            m_busy[d] = 1'b0;
            m_full[d] = 1'b0;
            m_done[d] = 1'b0;
            m_t[d]    = 0;
         end else begin
            acc       = dv && !m_full[d];
            m_done[d] = 1'b0;
            if (m_busy[d]) begin
               m_t[d]++;
               if (m_t[d] == frame_len(d)) begin
                  m_busy[d] = 1'b0;
                  m_done[d] = 1'b1;
               end
            end
            if (!m_busy[d] && m_full[d]) begin
               m_frame[d] = build(d, m_hold[d]);
               m_t[d]     = 0;
               m_busy[d]  = 1'b1;
               m_full[d]  = 1'b0;
            end
            if (acc) begin
               m_full[d] = 1'b1;
               m_hold[d] = tx_byte;
            end
         end
      end
   endtask

   task automatic chk(string tag, int d, logic obs, logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s dut%0d cycle %0d: observed %b expected %b", tag, d, cyc, obs, exp);
      end
   endtask

   task automatic chk_int(string tag, int obs, int exp);
      n_cmp++;
      assert (obs == exp) else begin
         n_fail++;
         $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_all();
      logic exp_ser;
      for (int d = 0; d < N; d++) begin
         exp_ser = m_busy[d] ? m_frame[d][m_t[d] / CPB[d]] : 1'b1;
         chk("serial", d, serial[d], exp_ser);
         chk("active", d, active[d], m_busy[d]);
         chk("ready",  d, ready[d],  !m_full[d]);
         chk("done",   d, done[d],   m_done[d]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      check_all();
   endtask

   logic       log_a [64];
   logic       log_b [64];
   logic       log_c [64];
   logic [9:0] pat;
   int         cnt_act, first_done, run, max_run, n_done;

   initial begin
      // Reset with valid asserted: must be ignored
      rst = 1'b1; dv = 1'b1; tx_byte = 9'($urandom);
      repeat (3) tick();
      rst = 1'b0; dv = 1'b0;
      repeat (2) tick();

      // 0xA5 on the 4/8/none/1 configuration; input changes mid-frame
      tx_byte = 9'h0A5; dv = 1'b1;
      tick();
      dv = 1'b0;
      for (int k = 0; k < 42; k++) begin
         tx_byte = 9'($urandom);
         tick();
         log_a[k] = serial[0];
         log_b[k] = active[0];
         log_c[k] = done[0];
      end
      pat = 10'b1101001010;
      for (int b = 0; b < 10; b++) chk("a5_bit", 0, log_a[4*b+1], pat[b]);
      cnt_act = 0; first_done = -1;
      for (int k = 0; k < 42; k++) begin
         if (log_b[k]) cnt_act++;
         if (log_c[k] && first_done < 0) first_done = k;
      end
      chk_int("a5_active_len", cnt_act, 40);
      chk_int("a5_done_cycle", first_done, 40);
      repeat (10) tick();

      // 0x07 with 7 data bits: even parity 1, odd parity 0
      tx_byte = 9'h007; dv = 1'b1;
      tick();
      dv = 1'b0;
      for (int k = 0; k < 42; k++) begin
         tick();
         log_a[k] = serial[1];
         log_b[k] = serial[2];
         log_c[k] = active[1];
      end
      chk("even_parity", 1, log_a[33], 1'b1);
      chk("odd_parity",  2, log_b[33], 1'b0);
      cnt_act = 0;
      for (int k = 0; k < 42; k++) if (log_c[k]) cnt_act++;
      chk_int("parity_frame_len", cnt_act, 40);
      repeat (10) tick();

      // Back-to-back 0x00, 0xFF with two stop bits; third payload blocked
      run = 0; max_run = 0; n_done = 0;
      dv = 1'b1; tx_byte = 9'h000;
      for (int k = 0; k < 128; k++) begin
         if (k == 1) tx_byte = 9'h0FF;
         if (k == 3) tx_byte = 9'h03C;
         if (k == 8) dv = 1'b0;
         tick();
         if (k >= 3 && k < 8) chk("third_blocked", 4, ready[4], 1'b0);
         run = active[4] ? run + 1 : 0;
         if (run > max_run) max_run = run;
         if (done[4]) n_done++;
      end
      chk_int("b2b_active_run", max_run, 88);
      chk_int("b2b_done_count", n_done, 2);
      repeat (5) tick();

      // Reset in DATA with the holding register full
      dv = 1'b1; tx_byte = 9'h05A;
      tick();
      tx_byte = 9'h033;
      tick();
      tick();
      dv = 1'b0;
      repeat (4) tick();
      chk("pre_reset_full", 0, ready[0], 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int d = 0; d < N; d++) begin
         chk("rst_serial", d, serial[d], 1'b1);
         chk("rst_active", d, active[d], 1'b0);
         chk("rst_ready",  d, ready[d],  1'b1);
         chk("rst_done",   d, done[d],   1'b0);
      end
      cnt_act = 0;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (active[0] || done[0]) cnt_act++;
      end
      chk_int("held_discarded", cnt_act, 0);

      // Random traffic with occasional resets
      repeat (3000) begin
         rst     = ($urandom_range(0, 299) == 0);
         dv      = ($urandom_range(0, 2) == 0);
         tx_byte = 9'($urandom);
         tick();
      end
      rst = 1'b0; dv = 1'b0;
      repeat (100) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
